// File: rtl/dbg_run_ctrl_pkg.sv
// Shared encodings for the run/stop controller: system states, stop causes, stop modes, key roles.
// No logic lives here; the controller and its interface both consume these constants.
package dbg_run_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'b00,
        S_RUN  = 2'b01,
        S_STP  = 2'b10,
        S_STEP = 2'b11
    } state_t;

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_MANUAL = 3'd1;
    localparam logic [2:0] CAUSE_STEP   = 3'd2;
    localparam logic [2:0] CAUSE_INTR   = 3'd3;
    localparam logic [2:0] CAUSE_BRK    = 3'd4;
    localparam logic [2:0] CAUSE_HALT   = 3'd5;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_INTR = 2'd1;
    localparam logic [1:0] MODE_IMM  = 2'd2;
    localparam logic [1:0] MODE_STEP = 2'd3;

    localparam int K_RST = 0;
    localparam int K_RUN = 1;
    localparam int K_CLR = 2;
    localparam int K_INC = 3;

endpackage

// File: rtl/dbg_run_ctrl_if.sv
// CPU-facing signal bundle of the run/stop controller; master = controller, slave = CPU side.
// Purely combinational wiring, no flow control.
interface dbg_run_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              insn_end;
    logic              intr_detected;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic              cpu_reset;
    logic              run_en;
    logic [ADDR_W-1:0] com_addr;

    modport master (
        input  insn_end, intr_detected, halted, pc,
        output cpu_reset, run_en, com_addr
    );

    modport slave (
        output insn_end, intr_detected, halted, pc,
        input  cpu_reset, run_en, com_addr
    );
endinterface

// File: rtl/dbg_run_ctrl_key_debounce.sv
// One push button: 2-flop sync, stability counter, registered press pulse.
// Latency raw edge -> pulse = 2 + DEB_CYCLES + 1 cycles; no backpressure.
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          deb_lvl;
    logic          prev_lvl;
    logic [CW-1:0] cnt;

    // The counter only runs while the synced level disagrees with the accepted one,
    // so any return to the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            deb_lvl  <= 1'b1;
            prev_lvl <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= key_raw_n;
            sync2    <= sync1;
            prev_lvl <= deb_lvl;
            press    <= prev_lvl & ~deb_lvl;
            if (sync2 == deb_lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt     <= '0;
                deb_lvl <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dbg_run_ctrl.sv
// Board run/stop controller: debounced keys drive the RST/RUN/STP/STEP machine, PC breakpoints, browse address.
// Stops take effect the cycle after the condition; no backpressure, CPU is gated through run_en.
module dbg_run_ctrl
    import dbg_run_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int NBRK       = 2,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             key_n,
    input  logic [1:0]             stop_mode,
    input  logic [NBRK*ADDR_W-1:0] brk_addr,
    input  logic [NBRK-1:0]        brk_en,
    dbg_run_ctrl_if.master         cpu,
    output logic [1:0]             state,
    output logic [2:0]             stop_cause,
    output logic [NBRK-1:0]        brk_hit,
    output logic [CNT_W-1:0]       insn_cnt,
    output logic [3:0]             key_pulse
);
    state_t            st;
    logic [ADDR_W-1:0] browse_addr;
    logic              skip_brk;
    logic [NBRK-1:0]   brk_match;
    logic [NBRK-1:0]   brk_first;
    logic              brk_stop;
    logic [2:0]        run_cause;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw_n (key_n[k]),
            .press     (key_pulse[k])
        );
    end

    always_comb begin
        brk_match = '0;
        for (int i = 0; i < NBRK; i++) begin
            brk_match[i] = brk_en[i] && (cpu.pc == brk_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    // Isolate the lowest set bit so a multi-slot match reports one slot.
    assign brk_first = brk_match & (~brk_match + 1'b1);
    assign brk_stop  = cpu.insn_end && !skip_brk && (|brk_match);

    always_comb begin
        run_cause = CAUSE_NONE;
        if (cpu.halted && key_pulse[K_RUN])
            run_cause = CAUSE_HALT;
        else if (stop_mode == MODE_INTR && cpu.insn_end && cpu.intr_detected)
            run_cause = CAUSE_INTR;
        else if (stop_mode == MODE_IMM)
            run_cause = CAUSE_MANUAL;
        else if (stop_mode == MODE_STEP && cpu.insn_end)
            run_cause = CAUSE_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_RST;
            browse_addr <= '0;
            stop_cause  <= CAUSE_NONE;
            brk_hit     <= '0;
            insn_cnt    <= '0;
            skip_brk    <= 1'b0;
        end else begin
            if (cpu.run_en && cpu.insn_end && insn_cnt != '1)
                insn_cnt <= insn_cnt + 1'b1;
            if (cpu.insn_end)
                skip_brk <= 1'b0;

            if (key_pulse[K_RST] && st != S_RST) begin
                st          <= S_RST;
                insn_cnt    <= '0;
                browse_addr <= '0;
                skip_brk    <= 1'b0;
            end else begin
                case (st)
                    S_RST: begin
                        insn_cnt    <= '0;
                        browse_addr <= '0;
                        skip_brk    <= 1'b0;
                        if (key_pulse[K_RST]) begin
                            st <= S_RUN;
                        end else if (key_pulse[K_RUN]) begin
                            st         <= S_STP;
                            stop_cause <= CAUSE_MANUAL;
                            brk_hit    <= '0;
                        end
                    end
                    S_RUN: begin
                        if (brk_stop) begin
                            st         <= S_STP;
                            stop_cause <= CAUSE_BRK;
                            brk_hit    <= brk_first;
                        end else if (run_cause != CAUSE_NONE) begin
                            st         <= S_STP;
                            stop_cause <= run_cause;
                            brk_hit    <= '0;
                        end
                    end
                    S_STP: begin
                        if (key_pulse[K_RUN]) begin
                            st       <= S_RUN;
                            skip_brk <= 1'b1;
                        end else if (key_pulse[K_CLR] && stop_mode == MODE_STEP) begin
                            st <= S_STEP;
                        end else if (key_pulse[K_CLR]) begin
                            browse_addr <= '0;
                        end else if (key_pulse[K_INC]) begin
                            browse_addr <= browse_addr + 1'b1;
                        end
                    end
                    S_STEP: begin
                        if (cpu.insn_end) begin
                            st         <= S_STP;
                            stop_cause <= CAUSE_STEP;
                            brk_hit    <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign state         = st;
    assign cpu.cpu_reset = (st == S_RST);
    assign cpu.run_en    = (st == S_RUN) || (st == S_STEP);
    assign cpu.com_addr  = (st == S_STP) ? browse_addr : cpu.pc;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl with hand-computed expectations (ADDR_W=8 keeps the browse wrap short).
module tb_dbg_run_ctrl;
    localparam int AW   = 8;
    localparam int NB   = 2;
    localparam int DEB  = 16;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      key_n;
    logic [1:0]      stop_mode;
    logic [NB*AW-1:0] brk_addr;
    logic [NB-1:0]   brk_en;
    logic [1:0]      state;
    logic [2:0]      stop_cause;
    logic [NB-1:0]   brk_hit;
    logic [CW-1:0]   insn_cnt;
    logic [3:0]      key_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int pcount;
    int lat;

    dbg_run_ctrl_if #(.ADDR_W(AW)) cpu_if ();

    dbg_run_ctrl #(.ADDR_W(AW), .NBRK(NB), .DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .stop_mode  (stop_mode),
        .brk_addr   (brk_addr),
        .brk_en     (brk_en),
        .cpu        (cpu_if.master),
        .state      (state),
        .stop_cause (stop_cause),
        .brk_hit    (brk_hit),
        .insn_cnt   (insn_cnt),
        .key_pulse  (key_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (key_pulse[0]) pcount++;
    endtask

    // Press keys in mask, wait for the debounced pulse, let the FSM act, then release and settle.
    task automatic press(input logic [3:0] mask);
        logic seen;
        seen = 1'b0;
        key_n = key_n & ~mask;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((key_pulse & mask) == mask) seen = 1'b1;
        end
        chk("press", {31'd0, seen}, 32'd1);
        @(negedge clk);
        key_n = key_n | mask;
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic insn(input logic [AW-1:0] a, input logic intr);
        cpu_if.pc            = a;
        cpu_if.intr_detected = intr;
        cpu_if.insn_end      = 1'b1;
        @(negedge clk);
        cpu_if.insn_end      = 1'b0;
        cpu_if.intr_detected = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        key_n = 4'hF;
        stop_mode = 2'd0;
        brk_addr = '0;
        brk_en = '0;
        cpu_if.insn_end = 1'b0;
        cpu_if.intr_detected = 1'b0;
        cpu_if.halted = 1'b0;
        cpu_if.pc = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_cpu_reset", cpu_if.cpu_reset, 1);
        chk("rst_run_en", cpu_if.run_en, 0);
        chk("rst_cnt", insn_cnt, 0);
        chk("rst_pulse", key_pulse, 0);
        chk("rst_cause", stop_cause, 0);
        chk("rst_brk_hit", brk_hit, 0);
        chk("rst_com_addr", cpu_if.com_addr, 8'h55);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Short glitches on K0 across 40 cycles, then a clean 30-cycle press.
        pcount = 0;
        for (int g = 0; g < 5; g++) begin
            key_n[0] = 1'b0;
            repeat (3) tick();
            key_n[0] = 1'b1;
            repeat (5) tick();
        end
        chk("glitch_pulses", pcount, 0);
        chk("glitch_state", state, 0);
        key_n[0] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (key_pulse[0] && lat == 0) lat = i;
        end
        chk("k0_latency", lat, 2 + DEB + 1);
        chk("k0_pulses", pcount, 1);
        chk("k0_state_run", state, 1);
        chk("k0_run_en", cpu_if.run_en, 1);
        chk("k0_cpu_reset", cpu_if.cpu_reset, 0);
        key_n[0] = 1'b1;
        repeat (DEB + 4) @(negedge clk);

        // Single-step stop in RUN.
        stop_mode = 2'd3;
        @(negedge clk);
        chk("mode3_still_run", state, 1);
        insn(8'h10, 1'b0);
        chk("step_stop_state", state, 2);
        chk("step_stop_cause", stop_cause, 2);
        chk("step_stop_cnt", insn_cnt, 1);
        chk("step_stop_run_en", cpu_if.run_en, 0);
        chk("stp_com_addr", cpu_if.com_addr, 0);

        // K2 in STP with stop_mode 3 enters STEP; next insn_end returns to STP.
        press(4'b0100);
        chk("step_state", state, 3);
        chk("step_run_en", cpu_if.run_en, 1);
        insn(8'h11, 1'b0);
        chk("step_done_state", state, 2);
        chk("step_done_cnt", insn_cnt, 2);
        chk("step_done_cause", stop_cause, 2);

        // Breakpoint on slot 1; slot 0 holds the same address but is disabled.
        stop_mode = 2'd0;
        brk_addr = {8'h24, 8'h24};
        brk_en = 2'b10;
        press(4'b0010);
        chk("resume_state", state, 1);
        insn(8'h20, 1'b0);
        chk("run_no_brk", state, 1);
        chk("run_cnt3", insn_cnt, 3);
        insn(8'h24, 1'b0);
        chk("brk_state", state, 2);
        chk("brk_cause", stop_cause, 4);
        chk("brk_hit", brk_hit, 2'b10);
        chk("brk_cnt", insn_cnt, 4);

        // Resume on the breakpointed PC: the first insn_end is skipped, the next re-stops.
        press(4'b0010);
        chk("brk_resume", state, 1);
        insn(8'h24, 1'b0);
        chk("brk_skip_state", state, 1);
        chk("brk_skip_cnt", insn_cnt, 5);
        insn(8'h24, 1'b0);
        chk("brk_rearm_state", state, 2);
        chk("brk_rearm_cause", stop_cause, 4);
        chk("brk_rearm_cnt", insn_cnt, 6);

        // Browse address: clear, increment, wrap, simultaneous clear+increment.
        press(4'b0100);
        chk("browse_clr", cpu_if.com_addr, 0);
        press(4'b1000);
        chk("browse_one", cpu_if.com_addr, 1);
        for (int i = 0; i < 254; i++) press(4'b1000);
        chk("browse_max", cpu_if.com_addr, 8'hFF);
        press(4'b1000);
        chk("browse_wrap", cpu_if.com_addr, 0);
        for (int i = 0; i < 3; i++) press(4'b1000);
        chk("browse_three", cpu_if.com_addr, 3);
        press(4'b1100);
        chk("browse_clr_wins", cpu_if.com_addr, 0);
        chk("browse_state", state, 2);

        // Halt stop: K1 while halted in RUN.
        brk_en = 2'b00;
        press(4'b0010);
        chk("halt_pre_run", state, 1);
        cpu_if.halted = 1'b1;
        press(4'b0010);
        chk("halt_state", state, 2);
        chk("halt_cause", stop_cause, 5);
        chk("halt_brk_hit_clr", brk_hit, 0);
        cpu_if.halted = 1'b0;

        // Interrupt stop.
        press(4'b0010);
        stop_mode = 2'd1;
        insn(8'h30, 1'b1);
        chk("intr_state", state, 2);
        chk("intr_cause", stop_cause, 3);
        chk("intr_cnt", insn_cnt, 7);

        // Immediate stop.
        stop_mode = 2'd0;
        press(4'b0010);
        chk("imm_pre_run", state, 1);
        stop_mode = 2'd2;
        @(negedge clk);
        chk("imm_state", state, 2);
        chk("imm_cause", stop_cause, 1);
        chk("imm_run_en", cpu_if.run_en, 0);
        stop_mode = 2'd0;

        // Asynchronous reset mid-RUN.
        press(4'b0010);
        chk("areset_pre_cnt", insn_cnt, 7);
        chk("areset_pre_state", state, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_state", state, 0);
        chk("areset_cnt", insn_cnt, 0);
        chk("areset_cpu_reset", cpu_if.cpu_reset, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // K1 in RST goes straight to STP; K0 from STP returns to RST.
        press(4'b0010);
        chk("rst_k1_state", state, 2);
        chk("rst_k1_cause", stop_cause, 1);
        press(4'b0001);
        chk("stp_k0_state", state, 0);
        chk("stp_k0_cpu_reset", cpu_if.cpu_reset, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
